// File: rtl/lfsr_seq_engine_if.sv
// rtl/lfsr_seq_engine_if.sv - run request and status bundle for the LFSR sequence engine
interface lfsr_seq_engine_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic             mode;
  logic [WIDTH-1:0] tap_mask;
  logic [WIDTH-1:0] seed;
  logic [CNT_W-1:0] seq_num;
  logic [WIDTH-1:0] num;
  logic             busy;
  logic             done;
  logic             step_valid;
  logic             lockup;

  modport master (
    output start, abort, mode, tap_mask, seed, seq_num,
    input  num, busy, done, step_valid, lockup
  );

  modport slave (
    input  start, abort, mode, tap_mask, seed, seq_num,
    output num, busy, done, step_valid, lockup
  );
endinterface

// File: rtl/lfsr_seq_engine.sv
// rtl/lfsr_seq_engine.sv - WIDTH-bit Fibonacci/Galois LFSR stepped a programmable number of times
module lfsr_seq_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  lfsr_seq_engine_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] num_q;
  logic [WIDTH-1:0] mask_q;
  logic [CNT_W-1:0] seqn_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mode_q;
  logic             busy_q;
  logic             done_q;
  logic             step_q;
  logic             lockup_q;
  logic [WIDTH-1:0] next_val;

  always_comb begin
    next_val = '0;
    if (mode_q) begin
      next_val = (num_q >> 1) ^ (num_q[0] ? mask_q : '0);
    end else begin
      next_val = {num_q[WIDTH-2:0], ^(num_q & mask_q)};
    end
  end

  // Step count is compared before incrementing, so cnt_q tops out at seqn_q and never wraps.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      num_q    <= ONE;
      mask_q   <= '0;
      seqn_q   <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      step_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      step_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mode_q   <= bus.mode;
            mask_q   <= bus.tap_mask;
            seqn_q   <= bus.seq_num;
            num_q    <= (bus.seed == '0) ? ONE : bus.seed;
            cnt_q    <= '0;
            lockup_q <= 1'b0;
            busy_q   <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (cnt_q == seqn_q) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end else if (next_val == '0) begin
            // Loading zero would freeze the register; keep the last live value instead.
            lockup_q <= 1'b1;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end else begin
            num_q  <= next_val;
            cnt_q  <= cnt_q + 1'b1;
            step_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.num        = num_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.step_valid = step_q;
  assign bus.lockup     = lockup_q;

endmodule

// File: doc/lfsr_seq_engine.md
Name: lfsr_seq_engine

Overview:
- Parametrised successor to the fixed 8-bit pseudo-random sequence generator.
- Runs a WIDTH-bit LFSR for a programmable number of steps and reports the final state.
- Taps are given by a full mask rather than a two-tap switch scan. Fibonacci or Galois form is selectable per run.
- Adds abort, a per-step output strobe, and all-zero lockup detection. Sits behind the user-project IO wrapper in place of the old generator.

Parameters:
- WIDTH, 8, LFSR state width; legal range 2..32.
- CNT_W, 8, width of the step-count input and the internal step counter.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- abort  in  1  terminate the current run; sampled only in RUN.
- mode  in  1  0 = Fibonacci, 1 = Galois; captured on start.
- tap_mask  in  WIDTH  feedback tap mask; captured on start.
- seed  in  WIDTH  initial state; captured on start.
- seq_num  in  CNT_W  number of shifts to perform; captured on start.
- num  out  WIDTH  current LFSR state (registered).
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse on normal completion or lockup.
- step_valid  out  1  one-cycle pulse after each shift; num is new that cycle.
- lockup  out  1  sticky; run ended because the next state would be all-zero.

Behaviour:
- Reset (synchronous, wb_rst_i=1 at an edge): state=IDLE, num=1, busy=0, done=0, step_valid=0, lockup=0, counter=0, captured registers=0. Reset mid-run takes effect at that edge; no done pulse.
- States: IDLE, RUN.
- IDLE with start=1 at edge E:
  - capture mode, tap_mask, seq_num;
  - num <= (seed==0) ? 1 : seed;
  - counter <= 0, lockup <= 0, busy <= 1, go RUN.
- start in RUN is ignored. abort in IDLE is ignored.
- Each RUN edge, in priority order:
  1. abort=1: go IDLE, busy<=0, no shift, done stays 0, num holds.
  2. counter==seq_num: go IDLE, busy<=0, done<=1.
  3. next==0: no load, num holds the last nonzero value, lockup<=1, done<=1, busy<=0, go IDLE.
  4. Otherwise: num<=next, counter<=counter+1, step_valid<=1.
- Next-state function:
  - Fibonacci: next = {num[WIDTH-2:0], ^(num & mask)}.
  - Galois: next = (num >> 1) ^ (num[0] ? mask : 0).
- Timing: busy is high for exactly seq_num+1 cycles on a full run, giving seq_num step_valid pulses.
  - done rises in the same cycle busy falls and lasts one cycle.
  - seq_num=0 gives one busy cycle, zero shifts, and num=seed.
- Back-to-back: start may be asserted in the done cycle. That cycle is IDLE, so the new run is accepted.
- Counter is CNT_W bits; seq_num max 2^CNT_W-1. The comparison is done before the increment, so the counter never wraps.
- num is stable whenever busy=0 and holds its last value until the next accepted start.

Test Plan:
- WIDTH=8, mode=0, mask=8'hB8, seed=8'h01, seq_num=4 → num steps 02,04,08,11 with 4 step_valid pulses; busy high 5 cycles; done pulse; final num=8'h11, lockup=0.
- Same mask and seed, seq_num=255 → 255 step_valid pulses; num never equals 8'h01 or 8'h00 before the last step; final num=8'h01 (maximal period).
- mode=1, mask=8'hB8, seed=8'h01, seq_num=2 → num 8'hB8 then 8'h5C; done pulse; final num=8'h5C.
- mode=0, mask=8'h00, seed=8'h80, seq_num=10 → no step_valid; lockup=1; done one cycle; busy high 1 cycle; num stays 8'h80. A following start with a good mask clears lockup.
- seed=8'h00, seq_num=0 → busy for 1 cycle, done pulse, num=8'h01.
- Interrupts on a Fibonacci run (mask 8'hB8, seed 8'h01, seq_num=100):
  - abort in the cycle of the 3rd step_valid → busy drops next edge, done never pulses, num=8'h08.
  - With wb_rst_i instead of abort → all outputs reach reset values at that edge, num=8'h01.
  - start pulsed during busy → ignored.
